gpio_ctrl_div: RTL and testbench

- Front-panel GPIO conditioning block with an integrated clock-enable divider.
- Drives masked output bits onto the front-panel GPIO bus and returns masked, synchronized input bits to core logic.
- Both directions refresh once every CLK_DIV_FAC clk cycles.
- Direction register is a constant.
- Sits between the transmit/scan control logic and the FPGA GPIO pins; single clock domain.

---
 rtl/gpio_ctrl_div_pkg.sv | 17 +
 rtl/clk_div_en.sv | 38 +++
 rtl/gpio_ctrl_div.sv | 57 +++++
 tb/tb_gpio_ctrl_div.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gpio_ctrl_div_pkg.sv
// Shared constants for the front-panel GPIO conditioning slice.
// Board masks and the divider counter width helper live here.
package gpio_ctrl_div_pkg;

    localparam int GPIO_REG_WIDTH_DFLT = 12;

    localparam logic [11:0] SYNC_OUT_MASK = 12'h555;
    localparam logic [11:0] TX_OUT_MASK   = 12'h800;
    localparam logic [11:0] BRD_IN_MASK   = 12'h022;
    localparam logic [11:0] BRD_DDR       = SYNC_OUT_MASK | TX_OUT_MASK;

    // Counter must hold 0..n-1; n+1 keeps the width sane for n=1.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_div_en.sv
// Clock-enable divider: free-running counter, one-cycle tick on the last count,
// and a registered divided clock low for N/2 cycles then high for the rest.
module clk_div_en
    import gpio_ctrl_div_pkg::*;
#(
    parameter int N = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick,
    output logic div_clk
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] HALF = CW'(N / 2);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    assign tick = (cnt == LAST);

    // div_clk is computed from the next count so it stays phase-aligned with cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            div_clk <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            div_clk <= (N > 1) && (cnt_next >= HALF);
        end
    end

endmodule

// File: rtl/gpio_ctrl_div.sv
// Front-panel GPIO conditioning: masked output register, two-flop input
// synchronizer and masked input register, both refreshed on the divider tick.
module gpio_ctrl_div
    import gpio_ctrl_div_pkg::*;
#(
    parameter int                        GPIO_REG_WIDTH = GPIO_REG_WIDTH_DFLT,
    parameter int                        CLK_DIV_FAC    = 10,
    parameter logic [GPIO_REG_WIDTH-1:0] OUT_MASK       = '0,
    parameter logic [GPIO_REG_WIDTH-1:0] IN_MASK        = '0,
    parameter logic [GPIO_REG_WIDTH-1:0] IO_DDR         = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] gpio_out,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_out,
    output logic [GPIO_REG_WIDTH-1:0] fp_gpio_ddr,
    output logic [GPIO_REG_WIDTH-1:0] gpio_in,
    output logic                      div_clk,
    output logic                      tick
);

    logic [GPIO_REG_WIDTH-1:0] s1;
    logic [GPIO_REG_WIDTH-1:0] s2;

    clk_div_en #(
        .N(CLK_DIV_FAC)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .div_clk(div_clk)
    );

    assign fp_gpio_ddr = IO_DDR;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= fp_gpio_in;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fp_gpio_out <= '0;
            gpio_in     <= '0;
        end else if (tick) begin
            fp_gpio_out <= gpio_out & OUT_MASK;
            gpio_in     <= s2 & IN_MASK;
        end
    end

endmodule

// File: tb/tb_gpio_ctrl_div.sv
// Directed bench: divide-by-10 and divide-by-1 GPIO blocks plus a standalone
// divide-by-20 divider, all sharing clock, reset and stimulus.
module tb_gpio_ctrl_div;
    import gpio_ctrl_div_pkg::*;

    logic        clk;
    logic        reset;
    logic [11:0] gpio_out;
    logic [11:0] fp_gpio_in;

    logic [11:0] fp_gpio_out, fp_gpio_ddr, gpio_in;
    logic        div_clk, tick;
    logic [11:0] fp_gpio_out1, fp_gpio_ddr1, gpio_in1;
    logic        div_clk1, tick1;
    logic        tick20, div_clk20;

    int total = 0;
    int bad   = 0;
    int unsigned k = 0;

    gpio_ctrl_div #(
        .GPIO_REG_WIDTH(12),
        .CLK_DIV_FAC   (10),
        .OUT_MASK      (12'hD55),
        .IN_MASK       (BRD_IN_MASK),
        .IO_DDR        (BRD_DDR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gpio_out   (gpio_out),
        .fp_gpio_in (fp_gpio_in),
        .fp_gpio_out(fp_gpio_out),
        .fp_gpio_ddr(fp_gpio_ddr),
        .gpio_in    (gpio_in),
        .div_clk    (div_clk),
        .tick       (tick)
    );

    gpio_ctrl_div #(
        .GPIO_REG_WIDTH(12),
        .CLK_DIV_FAC   (1),
        .OUT_MASK      (12'hD55),
        .IN_MASK       (12'h022),
        .IO_DDR        (12'h000)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .gpio_out   (gpio_out),
        .fp_gpio_in (fp_gpio_in),
        .fp_gpio_out(fp_gpio_out1),
        .fp_gpio_ddr(fp_gpio_ddr1),
        .gpio_in    (gpio_in1),
        .div_clk    (div_clk1),
        .tick       (tick1)
    );

    clk_div_en #(
        .N(20)
    ) u_div20 (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick20),
        .div_clk(div_clk20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s k=%0d got=%b exp=%b", tag, k, obs, exp);
        end
    endtask

    initial begin
        logic [11:0] e_out, e_out1, e_in, e_in1;

        reset      = 1'b1;
        gpio_out   = 12'hFFF;
        fp_gpio_in = 12'h000;

        // Reset hold for three edges with all output bits requested.
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("rst_out", fp_gpio_out, 12'h000);
            chk("rst_in", gpio_in, 12'h000);
            chk1("rst_div", div_clk, 1'b0);
            chk("rst_ddr", fp_gpio_ddr, 12'hD55);
            chk("rst_out1", fp_gpio_out1, 12'h000);
            chk1("rst_div20", div_clk20, 1'b0);
        end
        reset = 1'b0;

        // Edges after release; k counts them.
        for (int unsigned n = 1; n <= 56; n++) begin
            step();
            k = n;

            if (k < 10)       e_out = 12'h000;
            else if (k < 20)  e_out = 12'hD55;
            else              e_out = 12'h001;

            if (k <= 12)      e_out1 = 12'hD55;
            else if (k <= 15) e_out1 = 12'h001;
            else if (k <= 17) e_out1 = 12'hD55;
            else              e_out1 = 12'h001;

            e_in  = (k >= 30 && k < 50) ? 12'h022 : 12'h000;
            e_in1 = (k >= 24 && k <= 42) ? 12'h022 : 12'h000;

            chk("out", fp_gpio_out, e_out);
            chk("in", gpio_in, e_in);
            chk("out1", fp_gpio_out1, e_out1);
            chk("in1", gpio_in1, e_in1);
            chk1("div10", div_clk, (k % 10) >= 5);
            chk1("tick10", tick, (k % 10) == 9);
            chk1("div1", div_clk1, 1'b0);
            chk1("tick1", tick1, 1'b1);
            chk1("div20", div_clk20, (k % 20) >= 10);
            chk1("tick20", tick20, (k % 20) == 19);
            chk("ddr", fp_gpio_ddr, 12'hD55);

            case (k)
                12: gpio_out = 12'h001;
                15: gpio_out = 12'hFFF;
                17: gpio_out = 12'h001;
                21: fp_gpio_in = 12'hFFF;
                40: fp_gpio_in = 12'h000;
                default: ;
            endcase
        end

        // Mid-period reset with the counter at 6.
        reset = 1'b1;
        step();
        k = 100;
        chk1("mrst_tick", tick, 1'b0);
        chk1("mrst_div", div_clk, 1'b0);
        chk("mrst_out", fp_gpio_out, 12'h000);
        chk("mrst_out1", fp_gpio_out1, 12'h000);
        chk1("mrst_div20", div_clk20, 1'b0);
        reset = 1'b0;

        for (int unsigned r = 1; r <= 10; r++) begin
            step();
            k = 100 + r;
            chk1("post_tick", tick, r == 9);
            chk1("post_div", div_clk, r >= 5 && r < 10);
            chk("post_out", fp_gpio_out, (r == 10) ? 12'h001 : 12'h000);
            chk("post_out1", fp_gpio_out1, 12'h001);
            chk1("post_div20", div_clk20, r >= 10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
